// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake between a ratio source (master) and clk_div_ctrl (slave).
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider; ratio changes take effect only at a period boundary.
// Optional macro ODD_DUTY50_EN adds a negedge stage giving true 50% duty for odd divisors.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  clk_div_ctrl_if.slave       cfg,
  output logic                q,
  output logic                q_rise,
  output logic                busy
);

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] div, div_n;
  logic [CNT_W-1:0] pend, pend_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] high_n;
  logic             q_pos;
  logic             cfg_err_r;
  logic             xfer;
  logic             div_ok;
  logic             boundary;

  assign cfg.cfg_ready = (state != SWITCH);
  assign cfg.cfg_err   = cfg_err_r;
  assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
  assign div_ok        = (cfg.cfg_div >= CNT_W'(2));
  assign boundary      = (cnt == (div - CNT_W'(1)));
  assign high_n        = div_n - (div_n >> 1);

  // Next-state, counter and divisor selection; the old divisor owns the whole current period.
  always_comb begin
    state_n = state;
    div_n   = div;
    pend_n  = pend;
    cnt_n   = cnt;
    case (state)
      STOP: begin
        cnt_n = '0;
        if (xfer && div_ok) div_n = cfg.cfg_div;
        else                div_n = div;
        if (en) state_n = RUN;
        else    state_n = STOP;
      end
      RUN: begin
        if (boundary) begin
          cnt_n = '0;
          if (xfer && div_ok) div_n = cfg.cfg_div;
          else                div_n = div;
          if (en) state_n = RUN;
          else    state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (xfer && div_ok) begin
            pend_n  = cfg.cfg_div;
            state_n = SWITCH;
          end else begin
            state_n = RUN;
          end
        end
      end
      SWITCH: begin
        if (boundary) begin
          cnt_n = '0;
          div_n = pend;
          if (en) state_n = RUN;
          else    state_n = STOP;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          state_n = SWITCH;
        end
      end
      default: begin
        state_n = STOP;
        cnt_n   = '0;
      end
    endcase
  end

  // State registers; outputs are registered from the next-cycle counter so q lines up with cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= STOP;
      div       <= CNT_W'(DEFAULT_DIV);
      pend      <= '0;
      cnt       <= '0;
      q_pos     <= 1'b0;
      q_rise    <= 1'b0;
      busy      <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      pend      <= pend_n;
      cnt       <= cnt_n;
      q_pos     <= (state_n != STOP) && (cnt_n < high_n);
      q_rise    <= (state_n != STOP) && (cnt_n == '0);
      busy      <= (state_n != STOP);
      cfg_err_r <= xfer & ~div_ok;
    end
  end

`ifdef ODD_DUTY50_EN
  logic q_neg;

  // Half-cycle delayed copy of q_pos; ANDing trims half a cycle off odd-divisor high phases.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q_neg <= 1'b0;
    end else begin
      q_neg <= q_pos;
    end
  end

  assign q = div[0] ? (q_pos & q_neg) : q_pos;
`else
  assign q = q_pos;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed plus randomized bench for clk_div_ctrl against a period/phase reference model.
module tb_clk_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic q, q_rise, busy;

  clk_div_ctrl_if #(.CNT_W(8)) cfg ();

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .cfg    (cfg),
    .q      (q),
    .q_rise (q_rise),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: running flag, phase within the period, active divisor, queued divisor.
  bit m_run;
  int m_div;
  int m_phase;
  int m_pend[$];
  bit m_err;
  bit m_prev_qpos;

  function automatic void m_reset();
    m_run       = 1'b0;
    m_div       = 2;
    m_phase     = 0;
    m_pend.delete();
    m_err       = 1'b0;
    m_prev_qpos = 1'b0;
  endfunction

  function automatic bit m_qpos();
    return m_run && (m_phase < (m_div - m_div / 2));
  endfunction

  function automatic bit m_q();
`ifdef ODD_DUTY50_EN
    return m_qpos() && ((m_div % 2 == 0) || m_prev_qpos);
`else
    return m_qpos();
`endif
  endfunction

  function automatic void m_step(bit e, bit v, int d);
    bit accept;
    bit good;
    accept      = v && (m_pend.size() == 0);
    good        = accept && (d >= 2);
    m_err       = accept && (d < 2);
    m_prev_qpos = m_qpos();
    if (!m_run) begin
      if (good) m_div = d;
      m_phase = 0;
      m_run   = e;
    end else if (m_phase == m_div - 1) begin
      if (m_pend.size() != 0) m_div = m_pend.pop_front();
      else if (good) m_div = d;
      m_phase = 0;
      m_run   = e;
    end else begin
      if (good) m_pend.push_back(d);
      m_phase++;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle(input bit e, input bit v, input int d);
    en            = e;
    cfg.cfg_valid = v;
    cfg.cfg_div   = 8'(d);
    #1;
    chk("cfg_ready", 32'(cfg.cfg_ready), 32'(m_pend.size() == 0));
    @(posedge clk);
    m_step(e, v, d);
    #1;
    chk("q", 32'(q), 32'(m_q()));
    chk("q_rise", 32'(q_rise), 32'(m_run && m_phase == 0));
    chk("busy", 32'(busy), 32'(m_run));
    chk("cfg_err", 32'(cfg.cfg_err), 32'(m_err));
  endtask

  task automatic run_to_phase(input int ph);
    int guard;
    guard = 0;
    while (m_phase != ph && guard < 300) begin
      cycle(1'b1, 1'b0, 0);
      guard++;
    end
    chk("phase_reached", 32'(m_phase), 32'(ph));
  endtask

  initial begin
    m_reset();
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg.cfg_ready), 32'd1);
    chk("rst_err", 32'(cfg.cfg_err), 32'd0);
    rst = 1'b1;

    repeat (10) cycle(1'b0, 1'b0, 0);

    // divide by 2 from reset default
    repeat (8) cycle(1'b1, 1'b0, 0);

    // switch to 5 offered at phase 0, then a rejected divisor of 1
    run_to_phase(0);
    cycle(1'b1, 1'b1, 5);
    chk("switch_ready_low", 32'(cfg.cfg_ready), 32'd0);
    repeat (12) cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1);
    chk("err_pulse", 32'(cfg.cfg_err), 32'd1);
    repeat (10) cycle(1'b1, 1'b0, 0);
    chk("div_kept", 32'(m_div), 32'd5);

    // stop request mid-period, completes to the boundary
    run_to_phase(1);
    repeat (3) cycle(1'b0, 1'b0, 0);
    chk("stop_busy", 32'(busy), 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 0);
    chk("stopped_busy", 32'(busy), 32'd0);

    // direct change at the last cycle of a period, then odd/even ratios
    repeat (4) cycle(1'b1, 1'b0, 0);
    run_to_phase(4);
    cycle(1'b1, 1'b1, 3);
    chk("direct_ready", 32'(cfg.cfg_ready), 32'd1);
    repeat (9) cycle(1'b1, 1'b0, 0);
    run_to_phase(1);
    cycle(1'b1, 1'b1, 4);
    repeat (10) cycle(1'b1, 1'b0, 0);

    // asynchronous reset in the middle of a period
    run_to_phase(1);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    chk("async_rst_q", 32'(q), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(cfg.cfg_ready), 32'd1);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, int'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
